// File: rtl/fifo_packetizer.sv
// Pops bytes from a synchronous FIFO and emits fixed-length packets on a registered valid/ready stream.
// Define FIFO_PACKETIZER_CSUM_EN to append an XOR checksum trailer byte to every packet.
module fifo_packetizer #(
  parameter int unsigned PKT_LEN = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BCNT_W = 8;
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(PKT_LEN - 1);
`ifdef FIFO_PACKETIZER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_CSUM = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BCNT_W-1:0]   r_byte_cnt;
  logic                r_out_valid;
  logic [BYTE_W-1:0]   r_out_data;
  logic                r_out_sop;
  logic                r_out_eop;
  logic [CNT_W-1:0]    r_pkt_count;
  logic                w_slot_free;
  logic                w_last;
  logic                w_pop;
  logic                w_csum_load;
  logic [BYTE_W-1:0]   w_csum_byte;

  // Single-entry output register: room exists if empty or being drained this cycle
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_last      = (r_byte_cnt == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_pop && w_last) begin
`ifdef FIFO_PACKETIZER_CSUM_EN
          w_state_nxt = S_CSUM;
`else
          w_state_nxt = enable ? S_DATA : S_IDLE;
`endif
        end
      end
      S_CSUM: begin
`ifdef FIFO_PACKETIZER_CSUM_EN
        if (w_slot_free) begin
          w_state_nxt = enable ? S_DATA : S_IDLE;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop       = 1'b0;
    w_csum_load = 1'b0;
    busy        = 1'b0;
    w_pop       = (r_state == S_DATA) && !fifo_empty && w_slot_free;
`ifdef FIFO_PACKETIZER_CSUM_EN
    w_csum_load = (r_state == S_CSUM) && w_slot_free;
`endif
    busy        = (r_state != S_IDLE) || r_out_valid;
  end

  assign fifo_rd_en = w_pop;

`ifdef FIFO_PACKETIZER_CSUM_EN
  logic [BYTE_W-1:0] r_csum;

  // Running XOR restarts on the first data byte of each packet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= '0;
    end else if (w_pop) begin
      r_csum <= (r_byte_cnt == '0) ? fifo_rd_data : (r_csum ^ fifo_rd_data);
    end
  end

  assign w_csum_byte = r_csum;
`else
  assign w_csum_byte = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_pkt_count <= '0;
    end else if (w_pop) begin
      r_out_data  <= fifo_rd_data;
      r_out_valid <= 1'b1;
      r_out_sop   <= (r_byte_cnt == '0);
      r_out_eop   <= w_last && !CSUM_EN;
      if (w_last) begin
        r_byte_cnt <= '0;
        if (!CSUM_EN) begin
          r_pkt_count <= r_pkt_count + CNT_W'(1);
        end
      end else begin
        r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
      end
    end else if (w_csum_load) begin
      r_out_data  <= w_csum_byte;
      r_out_valid <= 1'b1;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b1;
      r_pkt_count <= r_pkt_count + CNT_W'(1);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign pkt_count = r_pkt_count;

endmodule
